// File: rtl/d_branch_unit.sv
// Decode-stage branch resolver: multi-mode operand compare plus a BHT of 2-bit saturating counters.
// Optional resolve/mispredict counters are built when D_BRANCH_STATS_EN is defined.
module d_branch_unit #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D_RD1,
    input  logic [WIDTH-1:0] D_RD2,
    input  logic [2:0]       D_CmpOp,
    input  logic             D_Branch,
    input  logic             D_Stall,
    input  logic [31:0]      D_PC,
    input  logic             D_PredTaken,
    input  logic [31:0]      F_PC,
    output logic             F_PredTaken,
    output logic             D_Taken,
    output logic             D_Zero,
    output logic             D_Mispredict,
    output logic [CNT_W-1:0] D_BranchCnt,
    output logic [CNT_W-1:0] D_MissCnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LEZ = 3'd2,
        CMP_GTZ = 3'd3,
        CMP_LTZ = 3'd4,
        CMP_GEZ = 3'd5,
        CMP_LT  = 3'd6,
        CMP_LTU = 3'd7
    } cmp_op_e;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] d_idx;
    logic [IDX_W-1:0] f_idx;
    logic             reset_d;
    logic             resolve;
    logic             taken;
    logic             rd1_neg;
    logic             rd1_zero;
    logic [1:0]       cur_entry;
    logic [1:0]       next_entry;
    logic             pc_unused;

    assign d_idx     = D_PC[IDX_W+1:2];
    assign f_idx     = F_PC[IDX_W+1:2];
    assign pc_unused = ^{D_PC[31:IDX_W+2], D_PC[1:0], F_PC[31:IDX_W+2], F_PC[1:0]};

    assign rd1_neg  = D_RD1[WIDTH-1];
    assign rd1_zero = (D_RD1 == '0);
    assign D_Zero   = (D_RD1 == D_RD2);

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        taken = 1'b0;
        case (cmp_op_e'(D_CmpOp))
            CMP_EQ:  taken = D_Zero;
            CMP_NE:  taken = ~D_Zero;
            CMP_LEZ: taken = rd1_neg | rd1_zero;
            CMP_GTZ: taken = ~rd1_neg & ~rd1_zero;
            CMP_LTZ: taken = rd1_neg;
            CMP_GEZ: taken = ~rd1_neg;
            CMP_LT:  taken = $signed(D_RD1) < $signed(D_RD2);
            CMP_LTU: taken = D_RD1 < D_RD2;
            default: taken = 1'b0;
        endcase
    end

    assign D_Taken      = taken;
    assign D_Mispredict = D_Branch & ~D_Stall & (taken ^ D_PredTaken);
    assign resolve      = D_Branch & ~D_Stall & ~reset;

    // Saturating 2-bit counter step for the entry being resolved.
    assign cur_entry = bht[d_idx];
    always_comb begin
        next_entry = cur_entry;
        if (taken) begin
            if (cur_entry != 2'b11) next_entry = cur_entry + 2'b01;
        end else begin
            if (cur_entry != 2'b00) next_entry = cur_entry - 2'b01;
        end
    end

    // NOTE: the BHT is a flop array, not a RAM, because every entry must restart weakly not-taken on reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            bht[d_idx] <= next_entry;
        end
    end

    always_ff @(posedge clk) begin
        reset_d <= reset;
    end

    // Prediction is masked while reset is held and for the cycle after it drops.
    assign F_PredTaken = bht[f_idx][1] & ~reset & ~reset_d;

`ifdef D_BRANCH_STATS_EN
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (resolve) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (D_Mispredict && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

    assign D_BranchCnt = branch_cnt;
    assign D_MissCnt   = miss_cnt;
`else
    assign D_BranchCnt = '0;
    assign D_MissCnt   = '0;
`endif

endmodule

// File: tb/tb_d_branch_unit.sv
// Directed self-checking bench for d_branch_unit (depth 16); stats checks follow D_BRANCH_STATS_EN.
module tb_d_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_rd1, d_rd2;
    logic [2:0]  d_cmp_op;
    logic        d_branch, d_stall, d_pred_taken;
    logic [31:0] d_pc, f_pc;
    logic        f_pred_taken, d_taken, d_zero, d_mispredict;
    logic [31:0] d_branch_cnt, d_miss_cnt;
    logic        s_f_pred_taken, s_d_taken, s_d_zero, s_d_mispredict;
    logic [2:0]  s_branch_cnt, s_miss_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    d_branch_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .D_RD1(d_rd1), .D_RD2(d_rd2), .D_CmpOp(d_cmp_op),
        .D_Branch(d_branch), .D_Stall(d_stall), .D_PC(d_pc), .D_PredTaken(d_pred_taken),
        .F_PC(f_pc), .F_PredTaken(f_pred_taken), .D_Taken(d_taken), .D_Zero(d_zero),
        .D_Mispredict(d_mispredict), .D_BranchCnt(d_branch_cnt), .D_MissCnt(d_miss_cnt)
    );

    // Narrow-counter instance sharing stimulus, used for saturation of the stats counters.
    d_branch_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .D_RD1(d_rd1), .D_RD2(d_rd2), .D_CmpOp(d_cmp_op),
        .D_Branch(d_branch), .D_Stall(d_stall), .D_PC(d_pc), .D_PredTaken(d_pred_taken),
        .F_PC(f_pc), .F_PredTaken(s_f_pred_taken), .D_Taken(s_d_taken), .D_Zero(s_d_zero),
        .D_Mispredict(s_d_mispredict), .D_BranchCnt(s_branch_cnt), .D_MissCnt(s_miss_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [7:0]  exp_taken;   // bit n = expected D_Taken for D_CmpOp n
        logic        exp_zero;
    } cmp_vec_t;

    cmp_vec_t vecs [5];

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 8'h56, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 8'h25, 1'b1};
        vecs[2] = '{32'h0000_0001, 32'hFFFF_FFFF, 8'hAA, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 8'hAA, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 8'h56, 1'b0};

        reset = 1'b1; d_rd1 = '0; d_rd2 = '0; d_cmp_op = 3'd0;
        d_branch = 1'b0; d_stall = 1'b0; d_pred_taken = 1'b0;
        d_pc = 32'h3000; f_pc = 32'h3000;

        // Reset: prediction masked during reset and the cycle after.
        step(); step();
        check("pred_in_reset", f_pred_taken, 1'b0);
        reset = 1'b0; #1;
        check("pred_after_reset", f_pred_taken, 1'b0);
        check("mp_no_branch", d_mispredict, 1'b0);
        step();
        for (int i = 0; i < 16; i++) begin
            f_pc = 32'h3000 + 32'(4 * i); #1;
            check($sformatf("sweep_pred_%0d", i), f_pred_taken, 1'b0);
        end
        // One taken resolve per entry: 01 -> 10 proves every entry started weakly not-taken.
        d_branch = 1'b1; d_cmp_op = 3'd0; d_rd1 = 32'h5; d_rd2 = 32'h5;
        for (int i = 0; i < 16; i++) begin
            d_pc = 32'h3000 + 32'(4 * i); f_pc = d_pc; #1;
            check($sformatf("train_mp_%0d", i), d_mispredict, 1'b1);
            step();
            check($sformatf("train_pred_%0d", i), f_pred_taken, 1'b1);
        end
        d_branch = 1'b0;
        do_reset();

        // EQ taken with pred=0: 01 -> 10 -> 11 -> 11, then decrement to 00 and saturate there.
        d_pc = 32'h3004; f_pc = 32'h3004; d_branch = 1'b1; d_cmp_op = 3'd0; #1;
        check("eq_taken", d_taken, 1'b1);
        check("eq_mp0", d_mispredict, 1'b1);
        check("eq_pred0", f_pred_taken, 1'b0);
        step();
        check("eq_pred1", f_pred_taken, 1'b1);
        check("eq_mp1", d_mispredict, 1'b1);
        step(); step();
        check("eq_pred_sat11", f_pred_taken, 1'b1);
        d_cmp_op = 3'd1; d_pred_taken = 1'b1; #1;
        check("ne_taken", d_taken, 1'b0);
        check("ne_mp", d_mispredict, 1'b1);
        step();
        check("dec_11_10", f_pred_taken, 1'b1);
        step();
        check("dec_10_01", f_pred_taken, 1'b0);
        step(); step();
        d_cmp_op = 3'd0; d_pred_taken = 1'b0;
        step();
        check("inc_00_01", f_pred_taken, 1'b0);
        step();
        check("inc_01_10", f_pred_taken, 1'b1);
        d_branch = 1'b0;

        // Compare sweep with D_Stall=1 so no training happens.
        d_branch = 1'b1; d_stall = 1'b1;
        for (int v = 0; v < 5; v++) begin
            d_rd1 = vecs[v].rd1; d_rd2 = vecs[v].rd2;
            for (int op = 0; op < 8; op++) begin
                d_cmp_op = 3'(op); #1;
                check($sformatf("cmp_v%0d_op%0d", v, op), d_taken, vecs[v].exp_taken[op]);
            end
            check($sformatf("zero_v%0d", v), d_zero, vecs[v].exp_zero);
            check($sformatf("stall_mp_v%0d", v), d_mispredict, 1'b0);
        end

        // Stalled branch must not train; release gives exactly one update.
        d_pc = 32'h3008; f_pc = 32'h3008; d_cmp_op = 3'd0; d_rd1 = 32'h9; d_rd2 = 32'h9;
        d_pred_taken = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("stall_mp_%0d", c), d_mispredict, 1'b0);
            step();
            check($sformatf("stall_pred_%0d", c), f_pred_taken, 1'b0);
        end
        d_stall = 1'b0; #1;
        check("release_mp", d_mispredict, 1'b1);
        step();
        check("release_pred", f_pred_taken, 1'b1);
        d_cmp_op = 3'd1;
        step();
        check("single_update", f_pred_taken, 1'b0);
        d_branch = 1'b0; d_cmp_op = 3'd0; #1;
        check("nobranch_mp", d_mispredict, 1'b0);
        step();
        check("nobranch_no_train", f_pred_taken, 1'b0);

        // Read-during-write on aliased index 0: old value this cycle, new value next.
        f_pc = 32'h3040; d_pc = 32'h3000; d_branch = 1'b1; #1;
        check("rdw_old", f_pred_taken, 1'b0);
        step();
        check("rdw_new", f_pred_taken, 1'b1);
        f_pc = 32'h3000; #1;
        check("alias_pred", f_pred_taken, 1'b1);
        d_branch = 1'b0;

`ifdef D_BRANCH_STATS_EN
        // 5 taken resolves, preds 0,0,1,1,1 -> 2 mispredicts; then 4 more with no misses.
        do_reset();
        d_pc = 32'h3010; d_branch = 1'b1; d_cmp_op = 3'd0;
        for (int k = 0; k < 5; k++) begin
            d_pred_taken = (k >= 2);
            step();
        end
        check("stats_branch5", d_branch_cnt, 32'd5);
        check("stats_miss2", d_miss_cnt, 32'd2);
        d_pred_taken = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("stats_branch9", d_branch_cnt, 32'd9);
        check("stats_miss_hold", d_miss_cnt, 32'd2);
        check("stats_small_sat", s_branch_cnt, 3'd7);
        check("stats_small_miss", s_miss_cnt, 3'd2);
        d_branch = 1'b0;
`else
        check("nostats_branch", d_branch_cnt, 32'd0);
        check("nostats_miss", d_miss_cnt, 32'd0);
`endif

        // Reset with a resolve pending: reset must win and leave the entry at 01.
        d_pc = 32'h3014; f_pc = 32'h3014; d_branch = 1'b1; d_stall = 1'b0; d_cmp_op = 3'd0;
        reset = 1'b1;
        step(); step();
        check("rst_r_pred", f_pred_taken, 1'b0);
`ifdef D_BRANCH_STATS_EN
        check("rst_r_branch_cnt", d_branch_cnt, 32'd0);
        check("rst_r_miss_cnt", d_miss_cnt, 32'd0);
`endif
        d_branch = 1'b0; reset = 1'b0;
        step();
        d_branch = 1'b1;
        step();
        d_cmp_op = 3'd1;
        step();
        d_branch = 1'b0; #1;
        check("rst_wins_entry01", f_pred_taken, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
